// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_if
// Description : Pipeline-side signal bundle of the hazard controller.
// Revision    : 1.0
// ============================================================================
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic             ResultSrcE0, PCSrcE, RegWriteM, RegWriteW;
    logic             MemReqM, MemReadyM;
    logic             StallF, StallD, StallE, StallM;
    logic             FlushD, FlushE, FlushW;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    // Pipeline side drives the register tags and memory handshake.
    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        input  ForwardAE, ForwardBE, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        output ForwardAE, ForwardBE, mem_err, stall_cnt, flush_cnt
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Stall/flush/forwarding control with memory-wait FSM and
//               saturating stall/flush performance counters.
// Revision    : 1.0
// ============================================================================
module hazard_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  wire logic     clk,
    input  wire logic     rst,
    hazard_ctrl_if.slave  hz
);
    localparam int                c_WC_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_WC_W-1:0] c_TIMEOUT = c_WC_W'(TIMEOUT);
    localparam logic [c_WC_W-1:0] c_WC_ONE  = c_WC_W'(1);
    localparam logic [CNT_W-1:0]  c_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]  c_CNT_MAX = {CNT_W{1'b1}};

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_WAIT = 1'b1;

    logic [0:0]        r_state, w_state_nxt;
    logic [c_WC_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
    logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;
    logic              w_mem_stall, w_mem_err, w_lw_stall, w_flush_evt;
    logic              w_stall_f, w_stall_d, w_stall_e, w_stall_m;
    logic              w_flush_d, w_flush_e, w_flush_w;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (hz.RegWriteM && (hz.RdM != 5'd0) && (hz.RdM == rs))
            return 2'b10;
        else if (hz.RegWriteW && (hz.RdW != 5'd0) && (hz.RdW == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        hz.ForwardAE = fwd_sel(hz.Rs1E);
        hz.ForwardBE = fwd_sel(hz.Rs2E);
    end

    assign w_lw_stall = hz.ResultSrcE0 && (hz.RdE != 5'd0) &&
                        ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            c_IDLE: begin
                if (hz.MemReqM && !hz.MemReadyM) begin
                    w_state_nxt    = c_WAIT;
                    w_wait_cnt_nxt = c_WC_ONE;
                end
            end
            c_WAIT: begin
                if (hz.MemReadyM || (r_wait_cnt == c_TIMEOUT)) begin
                    w_state_nxt    = c_IDLE;
                    w_wait_cnt_nxt = '0;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + c_WC_ONE;
                end
            end
            default: begin
                w_state_nxt    = c_IDLE;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    // Memory stall/timeout are gated by reset so nothing leaks while rst is held.
    always_comb begin
        w_mem_stall = 1'b0;
        w_mem_err   = 1'b0;
        if (!rst) begin
            case (r_state)
                c_IDLE: w_mem_stall = hz.MemReqM && !hz.MemReadyM;
                c_WAIT: begin
                    if (!hz.MemReadyM) begin
                        if (r_wait_cnt == c_TIMEOUT)
                            w_mem_err = 1'b1;
                        else
                            w_mem_stall = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_stall_f = 1'b0;
        w_stall_d = 1'b0;
        w_stall_e = 1'b0;
        w_stall_m = 1'b0;
        w_flush_d = 1'b0;
        w_flush_e = 1'b0;
        w_flush_w = 1'b0;
        if (rst) begin
            // all held low
        end else if (w_mem_stall) begin
            // Freeze everything upstream of MEM; a resolved branch is held in E.
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_stall_e = 1'b1;
            w_stall_m = 1'b1;
            w_flush_w = 1'b1;
        end else if (hz.PCSrcE) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
        end else if (w_lw_stall) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_flush_e = 1'b1;
        end
    end

    assign w_flush_evt = hz.PCSrcE && !w_mem_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_f && (r_stall_cnt != c_CNT_MAX))
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            if (w_flush_evt && (r_flush_cnt != c_CNT_MAX))
                r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
        end
    end

    assign hz.StallF    = w_stall_f;
    assign hz.StallD    = w_stall_d;
    assign hz.StallE    = w_stall_e;
    assign hz.StallM    = w_stall_m;
    assign hz.FlushD    = w_flush_d;
    assign hz.FlushE    = w_flush_e;
    assign hz.FlushW    = w_flush_w;
    assign hz.mem_err   = w_mem_err;
    assign hz.stall_cnt = r_stall_cnt;
    assign hz.flush_cnt = r_flush_cnt;
endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed + randomized bench for hazard_ctrl with reference model.
// Revision    : 1.0
// ============================================================================
module tb_hazard_ctrl;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(32)) bus ();
    hazard_ctrl_if #(.CNT_W(2))  bus2 ();

    hazard_ctrl #(.TIMEOUT(TO), .CNT_W(32)) dut     (.clk(clk), .rst(rst), .hz(bus));
    hazard_ctrl #(.TIMEOUT(TO), .CNT_W(2))  dut_sat (.clk(clk), .rst(rst), .hz(bus2));

    assign bus2.Rs1D        = bus.Rs1D;
    assign bus2.Rs2D        = bus.Rs2D;
    assign bus2.Rs1E        = bus.Rs1E;
    assign bus2.Rs2E        = bus.Rs2E;
    assign bus2.RdE         = bus.RdE;
    assign bus2.RdM         = bus.RdM;
    assign bus2.RdW         = bus.RdW;
    assign bus2.ResultSrcE0 = bus.ResultSrcE0;
    assign bus2.PCSrcE      = bus.PCSrcE;
    assign bus2.RegWriteM   = bus.RegWriteM;
    assign bus2.RegWriteW   = bus.RegWriteW;
    assign bus2.MemReqM     = bus.MemReqM;
    assign bus2.MemReadyM   = bus.MemReadyM;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd(input logic [4:0] rs);
        if (bus.RegWriteM && bus.RdM != 0 && bus.RdM == rs) return 2'b10;
        if (bus.RegWriteW && bus.RdW != 0 && bus.RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Reference model: tracks how many cycles a miss has been outstanding.
    bit     m_valid = 0;
    bit     m_busy  = 0;
    int     m_age   = 0;
    longint m_sc    = 0;
    longint m_fc    = 0;

    always @(negedge clk) begin
        logic ms, me, lw, sF, sD, sE, sM, fD, fE, fW;
        ms = 0; me = 0;
        if (!rst) begin
            if (!m_busy)
                ms = bus.MemReqM && !bus.MemReadyM;
            else if (!bus.MemReadyM) begin
                if (m_age == TO + 1) me = 1; else ms = 1;
            end
        end
        lw = bus.ResultSrcE0 && bus.RdE != 0 && (bus.RdE == bus.Rs1D || bus.RdE == bus.Rs2D);
        {sF, sD, sE, sM, fD, fE, fW} = '0;
        if (rst) ;
        else if (ms)          {sF, sD, sE, sM, fW} = '1;
        else if (bus.PCSrcE)  {fD, fE} = '1;
        else if (lw)          {sF, sD, fE} = '1;

        chk("m_fwdA", bus.ForwardAE, fwd(bus.Rs1E));
        chk("m_fwdB", bus.ForwardBE, fwd(bus.Rs2E));
        if (m_valid) begin
            chk("m_stall", {bus.StallF, bus.StallD, bus.StallE, bus.StallM}, {sF, sD, sE, sM});
            chk("m_flush", {bus.FlushD, bus.FlushE, bus.FlushW}, {fD, fE, fW});
            chk("m_memerr", bus.mem_err, me);
            chk("m_stall_cnt", bus.stall_cnt, sat(m_sc, 32));
            chk("m_flush_cnt", bus.flush_cnt, sat(m_fc, 32));
            chk("m_sat_stall_cnt", bus2.stall_cnt, sat(m_sc, 2));
            chk("m_sat_flush_cnt", bus2.flush_cnt, sat(m_fc, 2));
            chk("m_sat_outs", {bus2.StallF, bus2.FlushE, bus2.mem_err}, {sF, fE, me});
        end

        if (rst) begin
            m_valid = 1; m_busy = 0; m_age = 0; m_sc = 0; m_fc = 0;
        end else begin
            if (sF) m_sc++;
            if (bus.PCSrcE && !ms) m_fc++;
            if (!m_busy) begin
                if (bus.MemReqM && !bus.MemReadyM) begin m_busy = 1; m_age = 2; end
            end else if (bus.MemReadyM || me) m_busy = 0;
            else m_age++;
        end
    end

    task automatic idle_inputs();
        bus.Rs1D = 0; bus.Rs2D = 0; bus.Rs1E = 0; bus.Rs2E = 0;
        bus.RdE = 0; bus.RdM = 0; bus.RdW = 0;
        bus.ResultSrcE0 = 0; bus.PCSrcE = 0; bus.RegWriteM = 0; bus.RegWriteW = 0;
        bus.MemReqM = 0; bus.MemReadyM = 0;
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1; idle_inputs();
        nxt(); nxt();
        rst = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        nxt(); nxt();
        // Reset state; a pending miss must not stall while rst is held.
        bus.MemReqM = 1;
        settle();
        chk("rst_stallF", bus.StallF, 1'b0);
        chk("rst_memerr", bus.mem_err, 1'b0);
        chk("rst_stall_cnt", bus.stall_cnt, 0);
        chk("rst_flush_cnt", bus.flush_cnt, 0);
        nxt();
        rst = 0; bus.MemReqM = 0;

        // Forwarding
        bus.RdM = 5; bus.RegWriteM = 1; bus.RdW = 5; bus.RegWriteW = 1; bus.Rs1E = 5;
        settle();
        chk("fwdA_M", bus.ForwardAE, 2'b10);
        bus.RegWriteM = 0; #1;
        chk("fwdA_W", bus.ForwardAE, 2'b01);
        bus.Rs1E = 0; bus.RdM = 0; bus.RdW = 0; #1;
        chk("fwdA_none", bus.ForwardAE, 2'b00);
        nxt();
        bus.RdM = 7; bus.RegWriteM = 1; bus.RdW = 7; bus.Rs2E = 7;
        settle();
        chk("fwdB_M", bus.ForwardBE, 2'b10);
        nxt();

        // Load-use
        do_reset();
        bus.ResultSrcE0 = 1; bus.RdE = 3; bus.Rs2D = 3;
        settle();
        chk("lu_stall", {bus.StallF, bus.StallD, bus.StallE}, 3'b110);
        chk("lu_flush", {bus.FlushD, bus.FlushE}, 2'b01);
        nxt();
        bus.RdE = 0;
        settle();
        chk("lu_rd0", bus.StallF, 1'b0);
        chk("lu_cnt", bus.stall_cnt, 1);
        nxt();

        // Miss of 4 cycles
        do_reset();
        bus.MemReqM = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("miss_stall", {bus.StallF, bus.StallM, bus.FlushW}, 3'b111);
            nxt();
        end
        bus.MemReadyM = 1;
        settle();
        chk("miss_release", bus.StallF, 1'b0);
        nxt();
        bus.MemReqM = 0; bus.MemReadyM = 0;
        settle();
        chk("miss_cnt", bus.stall_cnt, 3);
        nxt();

        // Timeout
        do_reset();
        bus.MemReqM = 1;
        for (int i = 0; i < TO; i++) begin
            settle();
            chk("to_stall", {bus.StallF, bus.mem_err}, 2'b10);
            nxt();
        end
        settle();
        chk("to_err", {bus.StallF, bus.mem_err}, 2'b01);
        nxt();
        bus.MemReqM = 0;
        settle();
        chk("to_idle", {bus.StallF, bus.mem_err}, 2'b00);
        chk("to_cnt", bus.stall_cnt, TO);
        nxt();

        // Branch held during miss, then branch over load-use
        do_reset();
        bus.MemReqM = 1; bus.PCSrcE = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("br_frozen", {bus.StallF, bus.FlushD, bus.FlushE}, 3'b100);
            nxt();
        end
        bus.MemReadyM = 1;
        settle();
        chk("br_release", {bus.FlushD, bus.FlushE}, 2'b11);
        nxt();
        bus.MemReqM = 0; bus.MemReadyM = 0;
        bus.ResultSrcE0 = 1; bus.RdE = 3; bus.Rs1D = 3;
        settle();
        chk("br_over_lu", {bus.StallF, bus.StallD, bus.FlushD, bus.FlushE}, 4'b0011);
        chk("br_fcnt1", bus.flush_cnt, 1);
        nxt();
        idle_inputs();
        settle();
        chk("br_fcnt2", bus.flush_cnt, 2);
        nxt();

        // Reset in WAIT
        do_reset();
        bus.MemReqM = 1;
        nxt(); nxt();
        rst = 1;
        settle();
        chk("rw_outs", {bus.StallF, bus.mem_err}, 2'b00);
        nxt();
        rst = 0; bus.MemReqM = 0;
        settle();
        chk("rw_idle", {bus.StallF, bus.mem_err}, 2'b00);
        chk("rw_cnt", bus.stall_cnt, 0);
        nxt();

        // Saturation with CNT_W=2
        do_reset();
        bus.ResultSrcE0 = 1; bus.RdE = 3; bus.Rs2D = 3;
        repeat (5) nxt();
        bus.ResultSrcE0 = 0; bus.PCSrcE = 1;
        repeat (5) nxt();
        idle_inputs();
        settle();
        chk("sat_stall2", bus2.stall_cnt, 3);
        chk("sat_stall32", bus.stall_cnt, 5);
        chk("sat_flush2", bus2.flush_cnt, 3);
        chk("sat_flush32", bus.flush_cnt, 5);
        nxt();

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst             = ($urandom_range(0, 149) == 0);
            bus.Rs1D        = 5'($urandom_range(0, 7));
            bus.Rs2D        = 5'($urandom_range(0, 7));
            bus.Rs1E        = 5'($urandom_range(0, 7));
            bus.Rs2E        = 5'($urandom_range(0, 7));
            bus.RdE         = 5'($urandom_range(0, 7));
            bus.RdM         = 5'($urandom_range(0, 7));
            bus.RdW         = 5'($urandom_range(0, 7));
            bus.ResultSrcE0 = ($urandom_range(0, 2) == 0);
            bus.PCSrcE      = ($urandom_range(0, 4) == 0);
            bus.RegWriteM   = 1'($urandom_range(0, 1));
            bus.RegWriteW   = 1'($urandom_range(0, 1));
            bus.MemReqM     = ($urandom_range(0, 4) < 3);
            bus.MemReadyM   = ($urandom_range(0, 4) == 0);
            nxt();
        end
        rst = 0;
        idle_inputs();
        nxt();
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

- Pipeline hazard controller for the 5-stage core.
- Drives stall/flush into the IF/ID, ID/EX and EX/MEM pipeline registers, and bubble injection into MEM/WB.
- Generates EX-stage forwarding selects.
- Sequences multi-cycle data-memory accesses through a wait FSM with timeout, and keeps saturating stall/flush performance counters.

## Interface
Parameters:
- TIMEOUT, 64, max WAIT-state cycles before a memory access is abandoned (≥2)
- CNT_W, 32, performance counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- Rs1D, Rs2D  in  5  source regs of instruction in D
- Rs1E, Rs2E, RdE  in  5  sources/dest of instruction in E
- ResultSrcE0  in  1  instruction in E is a load
- PCSrcE  in  1  taken branch/jump resolved in E
- RdM, RdW  in  5  dest regs in M / W
- RegWriteM, RegWriteW  in  1  M / W write register file
- MemReqM  in  1  instruction in M accesses data memory
- MemReadyM  in  1  data memory completes access this cycle
- StallF, StallD, StallE, StallM  out  1  hold PC / IF-ID / ID-EX / EX-MEM
- FlushD, FlushE, FlushW  out  1  clear IF-ID / ID-EX / MEM-WB (bubble)
- ForwardAE, ForwardBE  out  2  00 regfile, 01 from W result, 10 from M ALU result
- mem_err  out  1  one-cycle pulse: memory access timed out
- stall_cnt, flush_cnt  out  CNT_W  performance counters

## Operation
- Forwarding (combinational):
  - ForwardAE = 10 if RegWriteM & RdM≠0 & RdM==Rs1E.
  - Else ForwardAE = 01 if RegWriteW & RdW≠0 & RdW==Rs1E.
  - Else ForwardAE = 00.
  - ForwardBE follows the same rule on Rs2E. M has priority over W.
- Load-use: lwStall = ResultSrcE0 & RdE≠0 & (RdE==Rs1D | RdE==Rs2D).
- Memory FSM, states IDLE, WAIT:
  - IDLE:
    - MemReqM & MemReadyM → no stall (single-cycle hit), stay IDLE.
    - MemReqM & !MemReadyM → memStall=1, next WAIT, wait_cnt←1.
  - WAIT:
    - MemReadyM → memStall=0, next IDLE.
    - Else if wait_cnt==TIMEOUT → memStall=0, mem_err=1, next IDLE.
    - Else memStall=1, wait_cnt←wait_cnt+1.
- Output priority, highest first:
  - memStall: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0. A branch in E stays frozen and is applied on release.
  - PCSrcE: FlushD=FlushE=1, StallF=StallD=0, regardless of lwStall.
  - lwStall: StallF=StallD=1, FlushE=1.
  - Otherwise all stall/flush outputs are 0.
- Counters:
  - stall_cnt increments every cycle StallF=1 (load-use or memory).
  - flush_cnt increments every cycle PCSrcE flush is applied (PCSrcE & !memStall).
  - Both saturate at 2^CNT_W−1, never wrap.

## Timing
- Forwarding, stall, flush and mem_err are combinational from inputs and current state; zero latency.
- FSM state, wait_cnt and counters update on posedge clk.
- Reset values: state IDLE, wait_cnt 0, stall_cnt 0, flush_cnt 0.
- While rst=1, all stall/flush outputs and mem_err are 0; forwarding stays combinational.
- rst asserted in WAIT → IDLE next edge, pending access abandoned, no mem_err.
- A miss of N cycles (MemReadyM high on Nth cycle after request, N≤TIMEOUT) produces exactly N−1 stalled cycles; the pipeline advances on the edge ending the ready cycle.
- Timeout: with MemReadyM never high, memStall is high for TIMEOUT cycles. mem_err pulses in cycle TIMEOUT+1, and the pipeline advances that edge.
- MemReqM low in WAIT is a protocol violation; state still follows MemReadyM/timeout.

## Test plan
- Forwarding: RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 → ForwardAE=10. Set RegWriteM=0 → 01. Set Rs1E=0 with RdM=RdW=0 → 00.
- Load-use: ResultSrcE0=1, RdE=3, Rs2D=3 → StallF=StallD=FlushE=1 for one cycle. stall_cnt +1. RdE=0 → no stall.
- Memory miss: MemReqM=1, MemReadyM high 4 cycles after request → StallF..StallM and FlushW high 3 cycles, then IDLE. stall_cnt +3.
- Timeout with TIMEOUT=4: MemReqM=1, MemReadyM=0 forever → 4 stalled cycles. mem_err=1 on cycle 5 with stalls 0. State returns to IDLE.
- Branch during miss: PCSrcE=1 while in WAIT → FlushD=FlushE=0 until MemReadyM. The next cycle gives FlushD=FlushE=1 and flush_cnt +1. With PCSrcE & lwStall both high → StallF=0, FlushD=FlushE=1.
- Reset mid-WAIT plus saturation: rst in WAIT → IDLE, counters 0, no mem_err. With CNT_W=2 and 5 load-use stalls → stall_cnt holds 3.
